// File: rtl/dac_sched_if.sv
// rtl/dac_sched_if.sv - channel request and serial DAC command bus for dac_sched
interface dac_sched_if #(
   parameter int NCH = 4
);
   logic [NCH-1:0]    req;
   logic [12*NCH-1:0] ch_data;
   logic [NCH-1:0]    ack;
   logic [15:0]       dac_din;
   logic              dac_din_vld;
   logic              dac_cs;

   modport master (
      input  req, ch_data, dac_cs,
      output ack, dac_din, dac_din_vld
   );

   modport slave (
      output req, ch_data, dac_cs,
      input  ack, dac_din, dac_din_vld
   );
endinterface

// File: rtl/dac_sched.sv
// rtl/dac_sched.sv - round-robin scheduler feeding channel codes to a serial DAC
// One frame in flight at a time; cs handshake from the serial side closes each frame.
module dac_sched #(
   parameter int NCH = 4,
   parameter int GAP = 8,
   parameter int TMO = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   dac_sched_if.master bus,
   output logic        busy,
   output logic        err_tmo
);
   localparam int CMAX = (TMO > GAP) ? TMO : GAP;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

   state_t        state;
   logic [1:0]    last_grant;
   logic [1:0]    grant;
   logic [CW-1:0] cnt;
   logic [1:0]    rr_idx;
   logic          rr_hit;
   logic [11:0]   rr_code;

   // Descending scan so the smallest offset after last_grant wins; offset NCH wraps to last_grant itself.
   always_comb begin
      rr_idx = last_grant;
      rr_hit = 1'b0;
      for (int i = NCH; i >= 1; i--) begin
         if (bus.req[last_grant + 2'(i)]) begin
            rr_idx = last_grant + 2'(i);
            rr_hit = 1'b1;
         end
      end
   end

   assign rr_code = bus.ch_data[int'(rr_idx) * 12 +: 12];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         last_grant      <= 2'd3;
         grant           <= 2'd0;
         cnt             <= '0;
         bus.ack         <= '0;
         bus.dac_din     <= '0;
         bus.dac_din_vld <= 1'b0;
         busy            <= 1'b0;
         err_tmo         <= 1'b0;
      end else begin
         bus.ack         <= '0;
         bus.dac_din_vld <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en && rr_hit) begin
                  grant           <= rr_idx;
                  last_grant      <= rr_idx;
                  bus.dac_din     <= {rr_idx, 2'b01, rr_code};
                  bus.dac_din_vld <= 1'b1;
                  busy            <= 1'b1;
                  state           <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt   <= '0;
               state <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (!bus.dac_cs) begin
                  cnt   <= '0;
                  state <= ST_WAIT_DONE;
               end else if (cnt == CW'(TMO - 1)) begin
                  err_tmo <= 1'b1;
                  cnt     <= '0;
                  state   <= ST_GAP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (bus.dac_cs) begin
                  bus.ack <= NCH'(1) << grant;
                  cnt     <= '0;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt == CW'(GAP - 1)) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dac_sched.sv
// tb/tb_dac_sched.sv - scoreboard bench for dac_sched with a behavioural serial DAC
module tb_dac_sched;
   localparam int GAP = 8;
   localparam int TMO = 255;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b0;
   logic busy;
   logic err_tmo;

   dac_sched_if #(.NCH(4)) bus ();

   dac_sched #(.NCH(4), .GAP(GAP), .TMO(TMO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .bus     (bus),
      .busy    (busy),
      .err_tmo (err_tmo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_din[$];
   logic [3:0]  exp_ack[$];
   logic [15:0] cur_din = '0;
   int          n_vld = 0;
   int          n_ack = 0;
   int          vld_cyc = 0;
   int          ack_cyc = 0;
   int          cs_rise_cyc = -1000;
   int          last_ack_cyc = -1;
   bit          chk_gap = 1'b0;
   bit          dac_stuck = 1'b0;
   bit          dac_active = 1'b0;
   bit          prev_vld = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Serial DAC: cs falls 3 cycles after the strobe and stays low 40 cycles.
   initial begin
      bus.dac_cs = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && bus.dac_din_vld && !dac_stuck) begin
            dac_active = 1'b1;
            repeat (3) @(posedge clk);
            #1 bus.dac_cs = 1'b0;
            repeat (40) @(posedge clk);
            #1 bus.dac_cs = 1'b1;
            cs_rise_cyc = cyc;
            dac_active  = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_vld = 1'b0;
      end else begin
         if (bus.dac_din_vld) begin
            check("vld_one_cycle", 32'(prev_vld), 0);
            check("vld_expected", 32'(exp_din.size() != 0), 1);
            if (exp_din.size() != 0) begin
               cur_din = exp_din.pop_front();
               check("dac_din", 32'(bus.dac_din), 32'(cur_din));
            end
            if (chk_gap && last_ack_cyc >= 0)
               check("regrant_gap", cyc - last_ack_cyc, GAP + 1);
            vld_cyc = cyc;
            n_vld++;
         end
         if (bus.ack != 4'b0000) begin
            check("ack_expected", 32'(exp_ack.size() != 0), 1);
            if (exp_ack.size() != 0)
               check("ack", 32'(bus.ack), 32'(exp_ack.pop_front()));
            check("ack_after_cs_rise", cyc - cs_rise_cyc, 1);
            check("din_hold", 32'(bus.dac_din), 32'(cur_din));
            last_ack_cyc = cyc;
            ack_cyc      = cyc;
            n_ack++;
         end
         prev_vld = bus.dac_din_vld;
      end
   end

   task automatic wait_cnt(input string name, input int target, input int budget, input bit is_ack);
      int k = 0;
      while (((is_ack ? n_ack : n_vld) < target) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'((is_ack ? n_ack : n_vld) >= target), 1);
   endtask

   task automatic wait_idle(input string name, input int budget, output int when);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < budget);
      check(name, 32'(busy), 0);
      when = cyc;
   endtask

   initial begin
      int v1, e1, i1, t0, nv, na, k;
      bus.req     = 4'b0000;
      bus.ch_data = {12'hDEF, 12'h789, 12'h456, 12'h123};
      en          = 1'b1;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_err_tmo", 32'(err_tmo), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_dac_din", 32'(bus.dac_din), 0);
      check("rst_vld", 32'(bus.dac_din_vld), 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // All channels requesting: round-robin 0,1,2,3,0 at minimum spacing.
      chk_gap      = 1'b1;
      last_ack_cyc = -1;
      exp_din.push_back(16'h1123); exp_ack.push_back(4'b0001);
      exp_din.push_back(16'h5456); exp_ack.push_back(4'b0010);
      exp_din.push_back(16'h9789); exp_ack.push_back(4'b0100);
      exp_din.push_back(16'hDDEF); exp_ack.push_back(4'b1000);
      exp_din.push_back(16'h1123); exp_ack.push_back(4'b0001);
      bus.req = 4'b1111;
      wait_cnt("rr_acks", 5, 400, 1'b1);
      bus.req = 4'b0000;
      chk_gap = 1'b0;
      wait_idle("rr_idle", 50, t0);
      check("rr_vld_count", n_vld, 5);

      // Single frame; ch_data moves after the grant but the word must not.
      bus.ch_data[11:0] = 12'hABC;
      nv = n_vld;
      na = n_ack;
      exp_din.push_back(16'h1ABC); exp_ack.push_back(4'b0001);
      bus.req = 4'b0001;
      wait_cnt("single_vld", nv + 1, 20, 1'b0);
      bus.ch_data[11:0] = 12'h555;
      wait_cnt("single_ack", na + 1, 100, 1'b1);
      bus.req = 4'b0000;
      wait_idle("single_idle", 20, t0);
      check("single_vld_count", n_vld - nv, 1);
      check("single_ack_latency", ack_cyc - vld_cyc, 44);

      // en low holds off the grant.
      en = 1'b0;
      nv = n_vld;
      na = n_ack;
      bus.req = 4'b0010;
      repeat (20) @(negedge clk);
      check("en0_no_vld", n_vld - nv, 0);
      check("en0_not_busy", 32'(busy), 0);
      exp_din.push_back(16'h5456); exp_ack.push_back(4'b0010);
      @(posedge clk);
      #1;
      en = 1'b1;
      t0 = cyc;
      wait_cnt("en1_vld", nv + 1, 10, 1'b0);
      check("en1_vld_within_2", 32'((vld_cyc - t0) <= 2), 1);
      check("en1_din_channel", 32'(bus.dac_din[15:14]), 32'(2'b01));
      wait_cnt("en1_ack", na + 1, 100, 1'b1);
      bus.req = 4'b0000;
      wait_idle("en1_idle", 20, t0);

      // cs never falls: timeout, no ack, then channel 2 granted again.
      dac_stuck = 1'b1;
      nv = n_vld;
      na = n_ack;
      exp_din.push_back(16'h9789);
      exp_din.push_back(16'h9789);
      bus.req = 4'b0100;
      wait_cnt("tmo_vld", nv + 1, 20, 1'b0);
      v1 = vld_cyc;
      k  = 0;
      while (!err_tmo && k < 300) begin
         @(negedge clk);
         k++;
      end
      e1 = cyc;
      check("tmo_err_set", 32'(err_tmo), 1);
      check("tmo_delay", e1 - v1, TMO + 1);
      wait_idle("tmo_idle", 20, i1);
      check("tmo_gap_len", i1 - e1, GAP);
      wait_cnt("tmo_regrant", nv + 2, 10, 1'b0);
      check("tmo_regrant_lat", vld_cyc - i1, 1);
      bus.req = 4'b0000;
      wait_idle("tmo_idle2", 300, i1);
      check("tmo_no_ack", n_ack - na, 0);
      check("tmo_sticky", 32'(err_tmo), 1);
      dac_stuck = 1'b0;

      // Reset in the middle of WAIT_DONE aborts silently.
      bus.ch_data[11:0] = 12'h123;
      nv = n_vld;
      na = n_ack;
      exp_din.push_back(16'h1123); exp_ack.push_back(4'b0001);
      bus.req = 4'b0001;
      wait_cnt("rst_vld_seen", nv + 1, 20, 1'b0);
      repeat (8) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_err_tmo", 32'(err_tmo), 0);
      check("midrst_ack", 32'(bus.ack), 0);
      check("midrst_dac_din", 32'(bus.dac_din), 0);
      check("midrst_vld", 32'(bus.dac_din_vld), 0);
      exp_ack.delete();
      bus.req = 4'b0000;
      @(negedge clk) rst_n = 1'b1;
      k = 0;
      while (dac_active && k < 60) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      check("midrst_no_ack", n_ack - na, 0);
      exp_din.push_back(16'hDDEF); exp_ack.push_back(4'b1000);
      bus.req = 4'b1000;
      wait_cnt("postrst_ack", na + 1, 100, 1'b1);
      check("postrst_vld_count", n_vld - nv, 2);
      bus.req = 4'b0000;
      wait_idle("postrst_idle", 20, t0);

      repeat (5) @(negedge clk);
      check("sb_din_drained", exp_din.size(), 0);
      check("sb_ack_drained", exp_ack.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
